// File: rtl/spi_flash_rd_if.sv
// spi_flash_rd_if
// Bundles the request channel, the output byte stream, the status flags and
// the SPI shift-engine handshake used by spi_flash_rd.
//   master : the surrounding system (requester, consumer, shift engine)
//   slave  : the spi_flash_rd sequencer itself
interface spi_flash_rd_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    // output byte stream
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout_data;
    logic        dout_last;
    // status
    logic        busy;
    logic        err;
    // shift-engine side
    logic        spi_en;
    logic        spi_cs;
    logic [79:0] spi_tx;
    logic [3:0]  spi_len;
    logic        spi_done;
    logic [79:0] spi_rx;

    modport master (
        output req_valid, req_addr, req_len, dout_ready, spi_done, spi_rx,
        input  req_ready, dout_valid, dout_data, dout_last, busy, err,
               spi_en, spi_cs, spi_tx, spi_len
    );

    modport slave (
        input  req_valid, req_addr, req_len, dout_ready, spi_done, spi_rx,
        output req_ready, dout_valid, dout_data, dout_last, busy, err,
               spi_en, spi_cs, spi_tx, spi_len
    );
endinterface

// File: rtl/spi_flash_rd.sv
// spi_flash_rd
// Splits a byte-level flash read request (start address, byte count) into
// READ frames of at most MAX_DATA data bytes, drives the SPI shift engine for
// each frame and unpacks the received bits into a valid/ready byte stream.
// Ports:
//   cclk  : clock
//   rst   : synchronous active-high reset
//   bus   : spi_flash_rd_if.slave -- request channel (req_*), byte stream
//           (dout_*), status (busy, err) and engine handshake (spi_*)
module spi_flash_rd #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int         MAX_DATA = 6,
    parameter int         TIMEOUT  = 1023
) (
    input  logic          cclk,
    input  logic          rst,
    spi_flash_rd_if.slave bus
);
    localparam int             RXW      = 8 * MAX_DATA;
    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [2:0]     MAXN     = 3'(MAX_DATA);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;   // one-cycle busy for a zero-length request

    logic [2:0]     state_q, state_d;
    logic [23:0]    addr_q, addr_d;
    logic [15:0]    rem_q, rem_d;
    logic [2:0]     chunk_q, chunk_d;
    logic [2:0]     idx_q, idx_d;
    logic [RXW-1:0] rx_q, rx_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic           req_ready_q, req_ready_d;
    logic           dout_valid_q, dout_valid_d;
    logic [7:0]     dout_data_q, dout_data_d;
    logic           dout_last_q, dout_last_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           spi_en_q, spi_en_d;
    logic           spi_cs_q, spi_cs_d;
    logic [79:0]    spi_tx_q, spi_tx_d;
    logic [3:0]     spi_len_q, spi_len_d;

    // Only the low RXW received bits can hold data; the rest is header echo.
    logic unused_rx;
    assign unused_rx = ^bus.spi_rx[79:RXW];

    // Header bytes in transmit order; data bytes are all zero so the
    // bit-reversed frame only ever has the 32 header bits populated.
    logic [31:0] hdr_be;
    logic [31:0] hdr_rev;
    assign hdr_be = {CMD_READ, addr_q};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rev
            assign hdr_rev[gi] = hdr_be[31 - gi];
        end
    endgenerate

    logic [2:0]  chunk_n;
    logic [15:0] chunk16;
    logic [2:0]  idx_nx;
    assign chunk_n = (rem_q < 16'(MAX_DATA)) ? rem_q[2:0] : MAXN;
    assign chunk16 = {13'd0, chunk_q};
    assign idx_nx  = idx_q + 3'd1;

    // Data byte k of an n-byte chunk: the last byte received sits lowest.
    function automatic logic [7:0] pick(input logic [RXW-1:0] rx,
                                        input logic [2:0]     n,
                                        input logic [2:0]     k);
        logic [2:0] pos;
        pos = n - k - 3'd1;
        return 8'(rx >> {pos, 3'b000});
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        chunk_d      = chunk_q;
        idx_d        = idx_q;
        rx_d         = rx_q;
        wdog_d       = wdog_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        spi_en_d     = spi_en_q;
        spi_cs_d     = spi_cs_q;
        spi_tx_d     = spi_tx_q;
        spi_len_d    = spi_len_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d  = bus.req_addr;
                    rem_d   = bus.req_len;
                    busy_d  = 1'b1;
                    state_d = (bus.req_len == 16'd0) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ISSUE: begin
                chunk_d   = chunk_n;
                spi_len_d = 4'd4 + {1'b0, chunk_n};
                spi_tx_d  = {48'd0, hdr_rev};
                spi_cs_d  = 1'b1;
                spi_en_d  = 1'b1;
                wdog_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    rx_d         = bus.spi_rx[RXW-1:0];
                    idx_d        = 3'd0;
                    spi_en_d     = 1'b0;
                    dout_valid_d = 1'b1;
                    dout_data_d  = pick(bus.spi_rx[RXW-1:0], chunk_q, 3'd0);
                    dout_last_d  = (rem_q == chunk16) && (chunk_q == 3'd1);
                    state_d      = S_DRAIN;
                end else if (wdog_q == WD_LIMIT) begin
                    err_d    = 1'b1;
                    spi_en_d = 1'b0;
                    spi_cs_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_DRAIN: begin
                // dout_valid is always high here, so ready alone is the handshake
                if (bus.dout_ready) begin
                    if (idx_q == chunk_q - 3'd1) begin
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        addr_d       = addr_q + {21'd0, chunk_q};
                        rem_d        = rem_q - chunk16;
                        spi_cs_d     = 1'b0;
                        if (rem_q == chunk16) begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        idx_d       = idx_nx;
                        dout_data_d = pick(rx_q, chunk_q, idx_nx);
                        dout_last_d = (rem_q == chunk16) && (idx_nx == chunk_q - 3'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            chunk_q      <= '0;
            idx_q        <= '0;
            rx_q         <= '0;
            wdog_q       <= '0;
            req_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            spi_en_q     <= 1'b0;
            spi_cs_q     <= 1'b0;
            spi_tx_q     <= '0;
            spi_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            chunk_q      <= chunk_d;
            idx_q        <= idx_d;
            rx_q         <= rx_d;
            wdog_q       <= wdog_d;
            req_ready_q  <= req_ready_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            spi_en_q     <= spi_en_d;
            spi_cs_q     <= spi_cs_d;
            spi_tx_q     <= spi_tx_d;
            spi_len_q    <= spi_len_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.spi_en     = spi_en_q;
    assign bus.spi_cs     = spi_cs_q;
    assign bus.spi_tx     = spi_tx_q;
    assign bus.spi_len    = spi_len_q;
endmodule

// File: tb/tb_spi_flash_rd.sv
// tb_spi_flash_rd
// Drives spi_flash_rd with a table of requests, hand-written corner cases and
// random requests. A behavioural flash/shift-engine model answers each frame;
// expected frames and bytes come from chunking the request arithmetically.
module tb_spi_flash_rd;
    localparam int TIMEOUT  = 1023;
    localparam int MAX_DATA = 6;

    logic cclk;
    logic rst;
    spi_flash_rd_if bif ();

    spi_flash_rd #(.CMD_READ(8'h03), .MAX_DATA(MAX_DATA), .TIMEOUT(TIMEOUT)) dut (
        .cclk (cclk),
        .rst  (rst),
        .bus  (bif)
    );

    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "global timeout");
    end

    typedef struct { logic [23:0] addr; int n; } frame_t;
    typedef struct { logic [7:0] d; logic last; } byte_t;
    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        int          bp;
        int          exp_frames;
        logic [23:0] exp_last_addr;
        int          exp_last_n;
    } vec_t;

    frame_t exp_frames[$];
    byte_t  exp_bytes[$];

    int checks = 0;
    int errors = 0;

    // bench-side state
    int          dr_mode = 0;       // 0 ready, 1 random, 2 stalled
    bit          eng_hang = 0;
    bit          eng_busy = 0;
    int          eng_cnt = 0;
    logic [79:0] eng_rx = '0;
    bit          force_en = 0;
    logic [79:0] force_rx = '0;
    bit          prev_en = 0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    logic [7:0]  prev_data = '0;
    logic [79:0] tx_lat = '0;
    logic [3:0]  len_lat = '0;
    int          frames_seen = 0;
    logic [23:0] last_frame_addr = '0;
    int          last_frame_n = 0;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[23:16] + 8'h5A);
    endfunction

    // Byte j of the transmitted stream: bits leave from spi_tx[0] upward, MSB first.
    function automatic logic [7:0] tx_byte(input logic [79:0] tx, input int j);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = tx[8*j+i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        byte_t  eb;
        frame_t f;
        logic [23:0] a;
        if (rst) begin
            prev_en    = 0;
            prev_valid = 0;
            return;
        end
        if (bif.spi_en && !prev_en) begin
            frames_seen++;
            a = {tx_byte(bif.spi_tx, 1), tx_byte(bif.spi_tx, 2), tx_byte(bif.spi_tx, 3)};
            last_frame_addr = a;
            last_frame_n    = int'(bif.spi_len) - 4;
            if (exp_frames.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_extra got addr %h expected no frame", a);
            end else begin
                f = exp_frames.pop_front();
                chk("frame_opcode", 80'(tx_byte(bif.spi_tx, 0)), 80'h03);
                chk("frame_addr", 80'(a), 80'(f.addr));
                chk("frame_len", 80'(bif.spi_len), 80'(4 + f.n));
                chk("frame_pad", bif.spi_tx >> 32, 80'd0);
                chk("frame_cs", 80'(bif.spi_cs), 80'd1);
            end
            tx_lat  = bif.spi_tx;
            len_lat = bif.spi_len;
        end else if (bif.spi_en && prev_en) begin
            chk("wait_tx_stable", bif.spi_tx, tx_lat);
            chk("wait_len_stable", 80'(bif.spi_len), 80'(len_lat));
        end
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", 80'(bif.dout_valid), 80'd1);
            chk("hold_data", 80'(bif.dout_data), 80'(prev_data));
        end
        if (bif.dout_valid && bif.dout_ready) begin
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_extra got %h expected no byte", bif.dout_data);
            end else begin
                eb = exp_bytes.pop_front();
                chk("byte_data", 80'(bif.dout_data), 80'(eb.d));
                chk("byte_last", 80'(bif.dout_last), 80'(eb.last));
            end
        end
        prev_en    = bif.spi_en;
        prev_valid = bif.dout_valid;
        prev_ready = bif.dout_ready;
        prev_data  = bif.dout_data;
    endtask

    // Flash + shift engine: the engine shifts L bytes in, each entering at bit 0.
    task automatic engine_step();
        logic [79:0] rx;
        logic [23:0] a;
        int          L;
        bif.spi_done = 1'b0;
        if (!bif.spi_en) begin
            eng_busy = 0;
            if (!eng_hang && $urandom_range(0, 7) == 0) begin
                bif.spi_done = 1'b1;          // stray pulse, must be ignored
                bif.spi_rx   = {$urandom, $urandom, 16'(5)};
            end
        end else if (!eng_busy) begin
            eng_busy = 1;
            eng_cnt  = eng_hang ? 0 : $urandom_range(1, 4);
            L  = int'(bif.spi_len);
            a  = {tx_byte(bif.spi_tx, 1), tx_byte(bif.spi_tx, 2), tx_byte(bif.spi_tx, 3)};
            rx = '0;
            for (int j = 0; j < L; j++)
                rx = (rx << 8) | ((j < 4) ? 80'hFF : 80'(fbyte(a + 24'(j - 4))));
            eng_rx = force_en ? force_rx : rx;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bif.spi_done = 1'b1;
                bif.spi_rx   = eng_rx;
            end
        end
    endtask

    task automatic tick();
        @(negedge cclk);
        monitor();
        @(posedge cclk);
        #1;
        engine_step();
        case (dr_mode)
            0:       bif.dout_ready = 1'b1;
            1:       bif.dout_ready = ($urandom_range(0, 2) != 0);
            default: bif.dout_ready = 1'b0;
        endcase
    endtask

    task automatic start_req(input logic [23:0] a, input logic [15:0] n, input bit push_data);
        int w = 0;
        logic [23:0] fa;
        int r;
        int c;
        while (!bif.req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_wait", 80'(bif.req_ready), 80'd1);
        fa = a;
        r  = int'(n);
        while (r > 0) begin
            c = (r < MAX_DATA) ? r : MAX_DATA;
            exp_frames.push_back('{addr: fa, n: c});
            fa = fa + 24'(c);
            r  = r - c;
        end
        if (push_data)
            for (int i = 0; i < int'(n); i++)
                exp_bytes.push_back('{d: fbyte(a + 24'(i)), last: (i == int'(n) - 1)});
        frames_seen     = 0;
        bif.req_valid   = 1'b1;
        bif.req_addr    = a;
        bif.req_len     = n;
        tick();
        bif.req_valid   = 1'b0;
        bif.req_addr    = 24'($urandom);
        bif.req_len     = 16'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (!(exp_bytes.size() == 0 && exp_frames.size() == 0 && !bif.busy) && c < bound) begin
            tick();
            c++;
        end
        if (c >= bound) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got bytes_left=%0d frames_left=%0d busy=%0b expected all drained",
                     exp_bytes.size(), exp_frames.size(), bif.busy);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 80'(bif.req_ready), 80'd0);
        chk({tag, "_dout_valid"}, 80'(bif.dout_valid), 80'd0);
        chk({tag, "_dout_data"}, 80'(bif.dout_data), 80'd0);
        chk({tag, "_dout_last"}, 80'(bif.dout_last), 80'd0);
        chk({tag, "_busy"}, 80'(bif.busy), 80'd0);
        chk({tag, "_err"}, 80'(bif.err), 80'd0);
        chk({tag, "_spi_en"}, 80'(bif.spi_en), 80'd0);
        chk({tag, "_spi_cs"}, 80'(bif.spi_cs), 80'd0);
        chk({tag, "_spi_tx"}, bif.spi_tx, 80'd0);
        chk({tag, "_spi_len"}, 80'(bif.spi_len), 80'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0]  hold_d;
        logic [23:0] ra;
        logic [15:0] rl;
        int          cnt;

        vecs[0] = '{24'h000100, 16'd3,  0, 1, 24'h000100, 3};
        vecs[1] = '{24'h000100, 16'd14, 0, 3, 24'h00010C, 2};
        vecs[2] = '{24'hFFFFFE, 16'd8,  1, 2, 24'h000004, 2};
        vecs[3] = '{24'h123456, 16'd6,  1, 1, 24'h123456, 6};
        vecs[4] = '{24'h000000, 16'd1,  0, 1, 24'h000000, 1};
        vecs[5] = '{24'hABCDEF, 16'd7,  1, 2, 24'hABCDF5, 1};
        vecs[6] = '{24'h000010, 16'd12, 0, 2, 24'h000016, 6};
        vecs[7] = '{24'h000000, 16'd0,  0, 0, 24'h000000, 0};

        rst            = 1'b1;
        bif.req_valid  = 1'b0;
        bif.req_addr   = '0;
        bif.req_len    = '0;
        bif.dout_ready = 1'b1;
        bif.spi_done   = 1'b0;
        bif.spi_rx     = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_req_ready", 80'(bif.req_ready), 80'd1);

        // basic read with fixed received bytes AA BB CC
        force_en = 1;
        force_rx = 80'hAABBCC;
        start_req(24'h000100, 16'd3, 0);
        exp_bytes.push_back('{d: 8'hAA, last: 1'b0});
        exp_bytes.push_back('{d: 8'hBB, last: 1'b0});
        exp_bytes.push_back('{d: 8'hCC, last: 1'b1});
        cnt = 0;
        while (!bif.spi_en && cnt < 20) begin tick(); cnt++; end
        chk("basic_hdr", 80'(bif.spi_tx[31:0]), 80'h008000C0);
        chk("basic_len", 80'(bif.spi_len), 80'd7);
        wait_done(200);
        force_en = 0;
        $display("txn basic addr=000100 len=3");

        // table of requests
        for (int v = 0; v < 8; v++) begin
            dr_mode = vecs[v].bp;
            start_req(vecs[v].addr, vecs[v].len, 1);
            wait_done(2000);
            chk("vec_frames", 80'(frames_seen), 80'(vecs[v].exp_frames));
            if (vecs[v].exp_frames > 0) begin
                chk("vec_last_addr", 80'(last_frame_addr), 80'(vecs[v].exp_last_addr));
                chk("vec_last_n", 80'(last_frame_n), 80'(vecs[v].exp_last_n));
            end
            $display("txn vec%0d addr=%h len=%0d frames=%0d", v, vecs[v].addr, vecs[v].len, frames_seen);
        end
        dr_mode = 0;

        // zero length: busy for exactly one cycle, no frame, no output
        start_req(24'h000500, 16'd0, 1);
        chk("len0_busy_hi", 80'(bif.busy), 80'd1);
        chk("len0_no_en", 80'(bif.spi_en), 80'd0);
        tick();
        chk("len0_busy_lo", 80'(bif.busy), 80'd0);
        chk("len0_ready", 80'(bif.req_ready), 80'd1);
        chk("len0_frames", 80'(frames_seen), 80'd0);
        chk("len0_no_out", 80'(bif.dout_valid), 80'd0);
        $display("txn len0 addr=000500 len=0");

        // backpressure mid-chunk
        dr_mode = 2;
        bif.dout_ready = 1'b0;
        start_req(24'h000400, 16'd6, 1);
        cnt = 0;
        while (!bif.dout_valid && cnt < 50) begin tick(); cnt++; end
        dr_mode = 0;
        bif.dout_ready = 1'b1;
        tick();
        tick();
        dr_mode = 2;
        bif.dout_ready = 1'b0;
        hold_d = bif.dout_data;
        chk("bp_third_byte", 80'(hold_d), 80'(fbyte(24'h000402)));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 80'(bif.dout_valid), 80'd1);
            chk("bp_hold_data", 80'(bif.dout_data), 80'(hold_d));
        end
        dr_mode = 0;
        bif.dout_ready = 1'b1;
        wait_done(200);
        $display("txn backpressure addr=000400 len=6");

        // watchdog abort
        eng_hang = 1;
        start_req(24'h000200, 16'd4, 0);
        cnt = 0;
        while (!bif.spi_en && cnt < 20) begin tick(); cnt++; end
        cnt = 0;
        while (!bif.err && cnt < TIMEOUT + 10) begin tick(); cnt++; end
        checks++;
        if (cnt < TIMEOUT || cnt > TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_cycles got %0d expected %0d..%0d", cnt, TIMEOUT, TIMEOUT + 1);
        end
        chk("tmo_en_low", 80'(bif.spi_en), 80'd0);
        chk("tmo_cs_low", 80'(bif.spi_cs), 80'd0);
        chk("tmo_busy_low", 80'(bif.busy), 80'd0);
        tick();
        chk("tmo_err_pulse", 80'(bif.err), 80'd0);
        chk("tmo_ready", 80'(bif.req_ready), 80'd1);
        chk("tmo_frames", 80'(frames_seen), 80'd1);
        eng_hang = 0;
        $display("txn timeout addr=000200 len=4 cycles=%0d", cnt);

        // reset during DRAIN
        dr_mode = 2;
        bif.dout_ready = 1'b0;
        start_req(24'h000300, 16'd6, 1);
        cnt = 0;
        while (!bif.dout_valid && cnt < 50) begin tick(); cnt++; end
        chk("rst_in_drain", 80'(bif.dout_valid), 80'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        exp_bytes.delete();
        exp_frames.delete();
        dr_mode = 0;
        bif.dout_ready = 1'b1;
        tick();
        chk("midrst_ready", 80'(bif.req_ready), 80'd1);
        chk("midrst_no_last", 80'(bif.dout_valid), 80'd0);
        $display("txn reset_in_drain addr=000300 len=6");

        // random requests
        for (int r = 0; r < 16; r++) begin
            ra = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 + 24'($urandom_range(0, 15))) : 24'($urandom);
            rl = 16'($urandom_range(0, 20));
            dr_mode = $urandom_range(0, 1);
            start_req(ra, rl, 1);
            wait_done(2000);
            chk("rand_frames", 80'(frames_seen), 80'((int'(rl) + MAX_DATA - 1) / MAX_DATA));
            $display("txn rand%0d addr=%h len=%0d frames=%0d", r, ra, rl, frames_seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_rd.md
Name: spi_flash_rd

Overview:
- Transaction sequencer sitting directly upstream of the SPI shift engine.
- Turns a byte-level read request (start address, byte count) into a series of flash READ transactions, each at most 10 bytes long.
- Unpacks the received shift-register contents into a byte stream with valid/ready flow control.
- Used by the boot/asset loader to stream data out of external SPI flash.

Parameters:
- CMD_READ, 8'h03, flash read opcode sent as the first byte of every transaction.
- MAX_DATA, 6, maximum data bytes per transaction (10-byte frame minus 4 header bytes); legal range 1..6.
- TIMEOUT, 1023, cycles to wait for spi_done before aborting.

Ports:
- cclk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  read request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  24  start byte address
- req_len  in  16  bytes to read; 0 is legal
- dout_valid  out  1  output byte present
- dout_ready  in  1  consumer accepts byte
- dout_data  out  8  output byte
- dout_last  out  1  marks the final byte of a request
- busy  out  1  high from request accept until return to IDLE
- err  out  1  one-cycle pulse on timeout abort
- spi_en  out  1  engine enable; the engine starts on its rising edge
- spi_cs  out  1  chip-select request to the engine (1 = select)
- spi_tx  out  80  frame to transmit; bit 0 is shifted out first
- spi_len  out  4  total frame length in bytes (4..10)
- spi_done  in  1  one-cycle pulse when the frame has completed
- spi_rx  in  80  received bits; each new bit enters at bit 0

Behaviour:
- Reset values: req_ready=0, dout_valid=0, dout_data=0, dout_last=0, busy=0, err=0, spi_en=0, spi_cs=0, spi_tx=0, spi_len=0. Internal counters are cleared and the FSM goes to IDLE.
- Reset mid-operation has the same effect immediately: spi_en drops, the partial chunk is discarded, and no dout_last is emitted.
- req_ready=1 only in IDLE.

FSM states:
- IDLE: on request accept, latch addr and remaining=req_len and set busy. If req_len==0, return to IDLE the next cycle with no engine activity and no output. Otherwise go to ISSUE.
- ISSUE (1 cycle): chunk n = min(remaining, MAX_DATA). Build frame bytes B0=CMD_READ, B1..B3 = addr[23:16], addr[15:8], addr[7:0], B4..B(3+n) = 8'h00. spi_len = 4+n. spi_tx = bit-reversal of the big-endian frame, so B0 bit 7 sits at spi_tx[0]. Unused high bits are 0. Assert spi_cs=1, spi_en=1, clear the watchdog, go to WAIT.
- WAIT: hold spi_en, spi_cs, spi_tx and spi_len stable. On spi_done, capture spi_rx, set idx=0, drop spi_en, go to DRAIN. If the watchdog reaches TIMEOUT, pulse err, drop spi_en/spi_cs, clear busy, and go to IDLE with the rest of the request abandoned.
- DRAIN: data byte k (0-based) of the chunk is rx[8*(n-1-k)+7 : 8*(n-1-k)], MSB-first within the byte.
  - Present bytes in order, holding dout_data stable while dout_valid && !dout_ready.
  - dout_last=1 only on the final byte of the whole request.
  - After byte n-1 is accepted: addr += n (wrapping modulo 2^24), remaining -= n, spi_cs=0.
  - If remaining==0, clear busy and go to IDLE; otherwise go to ISSUE.
- DRAIN always lasts at least one cycle, so spi_en is low for at least one cycle between frames and every ISSUE produces a fresh rising edge.
- spi_done outside WAIT is ignored.
- Throughput: one byte per cycle in DRAIN when dout_ready=1.

Test Plan:
- Basic read: req addr=24'h000100, len=3 -> one frame with spi_len=7 and header 03 00 01 00. With rx bytes AA BB CC, emit AA, BB, CC with dout_last only on CC.
- Chunking: len=14 -> three frames with data lengths 6, 6, 2 at addresses 0x000100, 0x000106, 0x00010C. Exactly 14 bytes are emitted and spi_en has a low gap before each frame.
- Wrap: addr=24'hFFFFFE, len=8 -> second frame addr=24'h000004.
- Backpressure: hold dout_ready=0 for 5 cycles mid-chunk -> dout_data is held and no byte is lost or duplicated.
- len=0 -> req accepted, busy high for 1 cycle, no spi_en edge, no output.
- Timeout and reset: withhold spi_done -> err pulses at TIMEOUT and the FSM returns to IDLE. Assert rst during DRAIN -> all outputs 0 on the next cycle.
